// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: denomination codes, coin values
// and controller state encoding.
package vending_pkg;

  typedef enum logic [1:0] {
    DENOM_NICKEL  = 2'd0,
    DENOM_DIME    = 2'd1,
    DENOM_QUARTER = 2'd2,
    DENOM_DOLLAR  = 2'd3
  } denom_e;

  localparam logic [15:0] VALUE_NICKEL  = 16'd5;
  localparam logic [15:0] VALUE_DIME    = 16'd10;
  localparam logic [15:0] VALUE_QUARTER = 16'd25;
  localparam logic [15:0] VALUE_DOLLAR  = 16'd100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  function automatic logic [15:0] coin_value(input logic [1:0] sel);
    logic [15:0] val;
    case (sel)
      DENOM_NICKEL:  val = VALUE_NICKEL;
      DENOM_DIME:    val = VALUE_DIME;
      DENOM_QUARTER: val = VALUE_QUARTER;
      DENOM_DOLLAR:  val = VALUE_DOLLAR;
      default:       val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/denom_picker.sv
// Combinational greedy selector: largest non-empty denomination that still
// fits in the amount owed.
module denom_picker
  import vending_pkg::*;
(
  input  logic [15:0] remaining,
  input  logic [3:0]  coin_empty,
  output logic [1:0]  sel,
  output logic        found
);

  // priority from the largest coin down
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    if (!coin_empty[3] && (remaining >= VALUE_DOLLAR)) begin
      sel   = DENOM_DOLLAR;
      found = 1'b1;
    end else if (!coin_empty[2] && (remaining >= VALUE_QUARTER)) begin
      sel   = DENOM_QUARTER;
      found = 1'b1;
    end else if (!coin_empty[1] && (remaining >= VALUE_DIME)) begin
      sel   = DENOM_DIME;
      found = 1'b1;
    end else if (!coin_empty[0] && (remaining >= VALUE_NICKEL)) begin
      sel   = DENOM_NICKEL;
      found = 1'b1;
    end else begin
      sel   = 2'd0;
      found = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: pays out an amount coin by coin through a
// handshaked hopper, with an acknowledge watchdog and a sticky fault.
module change_dispenser_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] change_amount,
  input  logic [3:0]  coin_empty,
  input  logic        eject_ack,
  output logic        eject_valid,
  output logic [1:0]  eject_sel,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] remaining
);

  localparam int unsigned     WD_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [15:0]       remaining_r;
  logic [1:0]        eject_sel_r;
  logic [WD_W-1:0]   wdog_r;
  logic [1:0]        pick_sel_s;
  logic              pick_found_s;
  logic              eject_valid_s;
  logic              busy_s;
  logic              done_s;
  logic              fault_s;
  logic              eject_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              fault_r;

  denom_picker u_picker (
    .remaining  (remaining_r),
    .coin_empty (coin_empty),
    .sel        (pick_sel_s),
    .found      (pick_found_s)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode; an ack on the final watchdog cycle still wins
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = start ? ST_SELECT : ST_IDLE;
      ST_SELECT: begin
        if (remaining_r == 16'd0) begin
          state_nxt_s = ST_DONE;
        end else if (pick_found_s) begin
          state_nxt_s = ST_EJECT;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      ST_EJECT: begin
        if (eject_ack) begin
          state_nxt_s = ST_SELECT;
        end else if (wdog_r == WD_LAST) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_EJECT;
        end
      end
      ST_DONE:   state_nxt_s = ST_IDLE;
      ST_FAULT:  state_nxt_s = start ? ST_SELECT : ST_FAULT;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // outputs decoded from the next state so the registered flags track the state
  always_comb begin
    eject_valid_s = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    fault_s       = 1'b0;
    case (state_nxt_s)
      ST_SELECT: busy_s = 1'b1;
      ST_EJECT: begin
        busy_s        = 1'b1;
        eject_valid_s = 1'b1;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      ST_FAULT: fault_s = 1'b1;
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // output flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eject_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      eject_valid_r <= eject_valid_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      fault_r       <= fault_s;
    end
  end

  // amount owed, coin in flight and acknowledge watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_r <= 16'd0;
      eject_sel_r <= 2'd0;
      wdog_r      <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FAULT: begin
          if (start) begin
            remaining_r <= change_amount;
          end
        end
        ST_SELECT: begin
          wdog_r <= '0;
          if ((remaining_r != 16'd0) && pick_found_s) begin
            eject_sel_r <= pick_sel_s;
          end
        end
        ST_EJECT: begin
          if (eject_ack) begin
            remaining_r <= remaining_r - coin_value(eject_sel_r);
          end else begin
            wdog_r <= wdog_r + WD_ONE;
          end
        end
        default: begin
          wdog_r <= '0;
        end
      endcase
    end
  end

  assign eject_valid = eject_valid_r;
  assign eject_sel   = eject_sel_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign fault       = fault_r;
  assign remaining   = remaining_r;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench for change_dispenser_ctrl: directed scenarios plus
// randomized transactions checked against a greedy change-making model.
module tb_change_dispenser_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] change_amount;
  logic [3:0]  coin_empty;
  logic        eject_ack;
  logic        eject_valid;
  logic [1:0]  eject_sel;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] remaining;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  bit exp_fault;
  int exp_rem;

  always #5 clk = ~clk;

  change_dispenser_ctrl #(.ACK_TIMEOUT(T)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .change_amount (change_amount),
    .coin_empty    (coin_empty),
    .eject_ack     (eject_ack),
    .eject_valid   (eject_valid),
    .eject_sel     (eject_sel),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .remaining     (remaining)
  );

  function automatic int cents(input int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  // greedy payout: repeatedly take the biggest available coin not exceeding the debt
  function automatic void build_model(input int amt, input logic [3:0] mask);
    int rem;
    int best;
    int bestv;
    exp_q.delete();
    exp_fault = 1'b0;
    rem = amt;
    while (rem > 0 && !exp_fault) begin
      best = -1;
      bestv = 0;
      for (int d = 0; d < 4; d++) begin
        if (mask[d] == 1'b0 && cents(d) <= rem && cents(d) > bestv) begin
          best = d;
          bestv = cents(d);
        end
      end
      if (best < 0) begin
        exp_fault = 1'b1;
      end else begin
        exp_q.push_back(best);
        rem -= bestv;
      end
    end
    exp_rem = rem;
  endfunction

  task automatic run_txn(input int amt, input logic [3:0] mask, input int max_delay,
                         input bit noise, input string name);
    int idx;
    int wait_cnt;
    int delay;
    int cycles;
    int exp_run;
    int want;
    bit finished;
    build_model(amt, mask);
    exp_run = amt;
    @(negedge clk);
    change_amount = 16'(amt);
    coin_empty = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || eject_valid !== 1'b0 || remaining !== 16'(amt) || fault !== 1'b0) begin
      errors++;
      $display("FAIL %s select_cycle: busy=%0b ev=%0b rem=%0d fault=%0b, want 1 0 %0d 0",
               name, busy, eject_valid, remaining, fault, amt);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() > 0 && eject_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s eject_latency: ev=%0b want 1", name, eject_valid);
    end else if (amt == 0 && done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_latency: done=%0b want 1", name, done);
    end
    idx = 0;
    wait_cnt = 0;
    delay = $urandom_range(0, max_delay);
    finished = 1'b0;
    cycles = 0;
    while (!finished && cycles < 3000) begin
      if (done === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (exp_fault || idx != exp_q.size() || remaining !== 16'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s done_state: coins=%0d rem=%0d busy=%0b, want coins=%0d rem=0 busy=1 fault_expected=%0b",
                   name, idx, remaining, busy, exp_q.size(), exp_fault);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: done=%0b busy=%0b, want 0 0", name, done, busy);
        end
      end else if (fault === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (!exp_fault || idx != exp_q.size() || remaining !== 16'(exp_rem) ||
            busy !== 1'b0 || eject_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s fault_state: coins=%0d rem=%0d busy=%0b ev=%0b, want coins=%0d rem=%0d busy=0 ev=0 fault_expected=%0b",
                   name, idx, remaining, busy, eject_valid, exp_q.size(), exp_rem, exp_fault);
        end
      end else if (eject_valid === 1'b1) begin
        want = (idx < exp_q.size()) ? exp_q[idx] : -1;
        checks++;
        if (want < 0 || eject_sel !== 2'(want)) begin
          errors++;
          $display("FAIL %s sel: coin %0d got %0d want %0d", name, idx, eject_sel, want);
        end
        if (wait_cnt == delay) begin
          coin_empty = mask;
          change_amount = 16'(amt);
          start = 1'b0;
          eject_ack = 1'b1;
          @(negedge clk);
          eject_ack = 1'b0;
          if (want >= 0) exp_run -= cents(want);
          checks++;
          if (eject_valid !== 1'b0 || remaining !== 16'(exp_run)) begin
            errors++;
            $display("FAIL %s after_ack: ev=%0b rem=%0d, want 0 %0d", name, eject_valid, remaining, exp_run);
          end
          idx++;
          wait_cnt = 0;
          delay = $urandom_range(0, max_delay);
        end else begin
          wait_cnt++;
          if (noise) begin
            coin_empty = 4'($urandom);
            start = 1'($urandom_range(0, 1));
            change_amount = 16'($urandom);
          end
        end
      end else begin
        finished = 1'b1;
        checks++;
        errors++;
        $display("FAIL %s unexpected_state: busy=%0b ev=%0b done=%0b fault=%0b", name, busy, eject_valid, done, fault);
      end
      if (!finished) begin
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    coin_empty = mask;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done or fault within budget", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    eject_ack = 1'b0;
    change_amount = 16'd0;
    coin_empty = 4'd0;
    #3;
    checks++;
    if ({eject_valid, eject_sel, busy, done, fault, remaining} !== 22'd0) begin
      errors++;
      $display("FAIL reset_values: ev=%0b sel=%0d busy=%0b done=%0b fault=%0b rem=%0d, want all 0",
               eject_valid, eject_sel, busy, done, fault, remaining);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(50, 4'b0000, 0, 1'b0, "amt50");
    run_txn(175, 4'b0000, 0, 1'b0, "amt175");
    run_txn(0, 4'b0000, 0, 1'b0, "amt0");
    run_txn(50, 4'b0100, 0, 1'b0, "amt50_no_quarter");
    run_txn(7, 4'b0000, 0, 1'b0, "amt7_fault");
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || remaining !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: fault=%0b rem=%0d busy=%0b, want 1 2 0", fault, remaining, busy);
    end
    run_txn(65, 4'b0000, 2, 1'b0, "restart_after_fault");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    change_amount = 16'd100;
    coin_empty = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (eject_valid !== 1'b1 || eject_sel !== 2'd3) begin
      errors++;
      $display("FAIL timeout_eject: ev=%0b sel=%0d, want 1 3", eject_valid, eject_sel);
    end
    repeat (T - 1) @(negedge clk);
    checks++;
    if (eject_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: ev=%0b fault=%0b, want 1 0", eject_valid, fault);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || remaining !== 16'd100 || busy !== 1'b0 || eject_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: fault=%0b rem=%0d busy=%0b ev=%0b, want 1 100 0 0",
               fault, remaining, busy, eject_valid);
    end
    eject_ack = 1'b1;
    @(negedge clk);
    eject_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || remaining !== 16'd100 || eject_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_fault: fault=%0b rem=%0d ev=%0b, want 1 100 0", fault, remaining, eject_valid);
    end
  endtask

  task automatic test_reset_mid_eject();
    @(negedge clk);
    change_amount = 16'd100;
    coin_empty = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({eject_valid, eject_sel, busy, done, fault, remaining} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_eject: ev=%0b sel=%0d busy=%0b done=%0b fault=%0b rem=%0d, want all 0",
               eject_valid, eject_sel, busy, done, fault, remaining);
    end
    @(negedge clk);
    reset = 1'b1;
    run_txn(30, 4'b0000, 1, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    int amt;
    logic [3:0] mask;
    for (int n = 0; n < 40; n++) begin
      amt = $urandom_range(0, 300);
      mask = 4'($urandom) & 4'($urandom);
      run_txn(amt, mask, 4, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid_eject();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser_ctrl.md
CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1000, cycles to wait for hopper acknowledge before faulting.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to dispense the amount on change_amount.
REQ-005 change_amount  input  16  change owed in cents, driven from the vending machine change output.
REQ-006 coin_empty  input  4  per-denomination hopper empty flags: [0]=nickel, [1]=dime, [2]=quarter, [3]=dollar.
REQ-007 eject_ack  input  1  hopper acknowledge; one coin released.
REQ-008 eject_valid  output  1  coin eject request to the hopper.
REQ-009 eject_sel  output  2  denomination code: 0=nickel, 1=dime, 2=quarter, 3=dollar.
REQ-010 busy  output  1  transaction in progress.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 fault  output  1  sticky fault flag.
REQ-013 remaining  output  16  cents still owed.

Function
REQ-014 States: IDLE, SELECT, EJECT, DONE, FAULT.
REQ-015 IDLE: on start=1 at a clock edge, latch change_amount into remaining, clear fault, go to SELECT.
REQ-016 start is ignored outside IDLE and FAULT; in FAULT, start behaves as in IDLE.
REQ-017 SELECT (one cycle): if remaining==0, go to DONE.
REQ-018 Otherwise, SELECT picks the largest denomination whose value is <= remaining and whose coin_empty bit is 0, then goes to EJECT.
REQ-019 SELECT goes to FAULT if no denomination qualifies, including when remaining is 1-4 cents.
REQ-020 EJECT: eject_valid=1 and eject_sel is held stable until eject_ack=1 is sampled at a clock edge.
REQ-021 On that ack edge: remaining decrements by the coin value (100/25/10/5) and the state returns to SELECT.
REQ-022 eject_ack is ignored outside EJECT.
REQ-023 eject_valid deasserts in the cycle after the ack edge; at most one coin is requested per ack.
REQ-024 A watchdog counter starts at 0 on entry to EJECT and increments each cycle without ack.
REQ-025 When the watchdog reaches ACK_TIMEOUT, go to FAULT with remaining unchanged.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE; remaining reads 0.
REQ-027 FAULT: fault=1 and remaining is held until the next start or reset; busy=0.
REQ-028 busy=1 in SELECT, EJECT and DONE; busy=0 otherwise.
REQ-029 Subtraction never underflows: selection guarantees coin value <= remaining.
REQ-030 Latency: start edge to first eject_valid = 2 cycles. Start with amount 0 to done pulse = 2 cycles.
REQ-031 coin_empty is sampled only in SELECT; changes during EJECT do not affect the coin in flight.

Reset
REQ-032 On reset=0, asynchronously: state=IDLE, eject_valid=0, eject_sel=0, busy=0, done=0, fault=0, remaining=0, watchdog=0.
REQ-033 Reset asserted mid-EJECT drops eject_valid immediately and discards the owed amount.
REQ-034 After reset deasserts, the first start is accepted at the next rising edge.

Structure
REQ-035 Package vending_pkg holds the denomination codes, the coin value constants and the state enumeration.
REQ-036 Sub-module denom_picker is combinational: remaining and coin_empty in; sel and found out.
REQ-037 Controller FSM, remaining register and watchdog stay in change_dispenser_ctrl.

Verification
REQ-038 Amount 50, immediate acks -> two quarter ejects (sel=2), done pulse, remaining=0.
REQ-039 Amount 175, immediate acks -> ejects dollar, quarter, quarter, quarter; done.
REQ-040 Amount 0 -> done 2 cycles after start, no eject_valid.
REQ-041 Amount 50, coin_empty[2]=1 -> five dime ejects (sel=1), done.
REQ-042 Amount 7 -> one nickel eject, then fault=1 with remaining=2; a new start clears fault.
REQ-043 Amount 100, eject_ack never asserted -> fault after ACK_TIMEOUT cycles, remaining=100.
REQ-044 Reset asserted mid-EJECT -> all outputs return to their reset values asynchronously.
